// File: rtl/midi_tx_pkg.sv
// Shared types and constants for the MIDI transmit arbiter.
package midi_tx_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_SYSEX, S_ABORT} state_e;

  typedef enum logic {GR_MSG, GR_SYSEX} grant_e;

  localparam logic [7:0] MIDI_EOX = 8'hF7;
  localparam logic [7:0] MIDI_SOX = 8'hF0;

  // Byte idx of a packed {status, data1, data2} short message, MSB first.
  function automatic logic [7:0] msg_byte(input logic [23:0] data, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = data[23:16];
      2'd1:    b = data[15:8];
      default: b = data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/midi_tx_out_reg.sv
// Single-byte holding register in front of the UART; exposes when a new byte may be loaded.
module midi_tx_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       slot
);

  // A byte may be loaded when the register is empty or is draining this cycle.
  assign slot = ~tx_valid | tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/midi_tx_arbiter.sv
// Schedules SysEx, short channel messages and realtime bytes onto one MIDI byte stream,
// keeping SysEx atomic and aborting a stalled SysEx message with a forced EOX.
module midi_tx_arbiter
  import midi_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sysex_valid,
  input  logic [7:0]  sysex_data,
  input  logic        sysex_last,
  output logic        sysex_rd,
  input  logic        msg_valid,
  input  logic [23:0] msg_data,
  input  logic [1:0]  msg_len,
  output logic        msg_ready,
  input  logic        rt_valid,
  input  logic [7:0]  rt_data,
  output logic        rt_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        sysex_abort,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        len_q, len_d;
  logic [23:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  grant_e            last_q, last_d;
  logic              abort_q, abort_d;

  logic              slot;
  logic              load;
  logic [7:0]        load_data;
  logic              sx_win;

  midi_tx_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .slot      (slot)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    last_d    = last_q;
    abort_d   = 1'b0;
    load      = 1'b0;
    load_data = 8'h00;
    sysex_rd  = 1'b0;
    msg_ready = 1'b0;
    rt_ready  = 1'b0;
    sx_win    = 1'b0;

    // Draining the remainder of an aborted message does not need the output slot.
    if (drop_q && sysex_valid) begin
      sysex_rd = 1'b1;
      if (sysex_last) drop_d = 1'b0;
    end

    if (slot && rt_valid && state_q != S_ABORT) begin
      load      = 1'b1;
      load_data = rt_data;
      rt_ready  = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (slot && !rt_valid) begin
          sx_win = sysex_valid && !drop_q && (!msg_valid || last_q == GR_MSG);
          if (sx_win) begin
            load      = 1'b1;
            load_data = sysex_data;
            sysex_rd  = 1'b1;
            last_d    = GR_SYSEX;
            cnt_d     = '0;
            if (!sysex_last) state_d = S_SYSEX;
          end else if (msg_valid) begin
            msg_ready = 1'b1;
            if (msg_len != 2'd0) begin
              load      = 1'b1;
              load_data = msg_data[23:16];
              data_d    = msg_data;
              len_d     = msg_len;
              last_d    = GR_MSG;
              if (msg_len > 2'd1) begin
                state_d = S_MSG;
                idx_d   = 2'd1;
              end
            end
          end
        end
      end
      S_MSG: begin
        if (slot && !rt_valid) begin
          load      = 1'b1;
          load_data = msg_byte(data_q, idx_q);
          idx_d     = idx_q + 2'd1;
          if (idx_q + 2'd1 == len_q) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
          end
        end
      end
      S_SYSEX: begin
        // Only an empty FIFO counts towards the timeout; output backpressure does not.
        if (!sysex_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_CNT) state_d = S_ABORT;
        end else if (slot && !rt_valid) begin
          load      = 1'b1;
          load_data = sysex_data;
          sysex_rd  = 1'b1;
          cnt_d     = '0;
          if (sysex_last) state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (slot) begin
          load      = 1'b1;
          load_data = MIDI_EOX;
          abort_d   = 1'b1;
          drop_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      len_q   <= 2'd0;
      data_q  <= 24'h0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      last_q  <= GR_MSG;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      last_q  <= last_d;
      abort_q <= abort_d;
    end
  end

  assign sysex_abort = abort_q;
  assign busy        = (state_q != S_IDLE) || tx_valid;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Self-checking bench for midi_tx_arbiter: directed scenarios plus a randomized run
// checked against a message-level model of the output stream.
module tb_midi_tx_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sysex_valid, sysex_last, sysex_rd;
  logic [7:0]  sysex_data;
  logic        msg_valid, msg_ready;
  logic [23:0] msg_data;
  logic [1:0]  msg_len;
  logic        rt_valid, rt_ready;
  logic [7:0]  rt_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        sysex_abort, busy;

  always #5 clk = ~clk;

  midi_tx_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sysex_valid (sysex_valid),
    .sysex_data  (sysex_data),
    .sysex_last  (sysex_last),
    .sysex_rd    (sysex_rd),
    .msg_valid   (msg_valid),
    .msg_data    (msg_data),
    .msg_len     (msg_len),
    .msg_ready   (msg_ready),
    .rt_valid    (rt_valid),
    .rt_data     (rt_data),
    .rt_ready    (rt_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .sysex_abort (sysex_abort),
    .busy        (busy)
  );

  // Source FIFOs as seen by the DUT: {last, byte}, {len, data}, realtime byte.
  logic [8:0]  sx_q[$];
  logic [25:0] m_q[$];
  logic [7:0]  rt_q[$];
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];

  int   total = 0, bad = 0;
  int   cyc = 0;
  int   abort_cnt = 0, sx_pops = 0, m_pops = 0, rt_pops = 0;
  bit   abort_on_eox = 0;
  bit   sx_pop_flag = 0, m_pop_flag = 0;
  logic [7:0] last_sx_pop = 8'h00;
  bit   tx_rdy_fix = 1, rnd_ready = 0, rnd_sx = 0, sx_en = 1;
  int   sx_low = 0;
  bit   hold_chk = 0;
  logic [7:0] held = 8'h00;

  task automatic drive();
    if (rnd_sx) begin
      sx_en = (sx_low >= 3) ? 1'b1 : ($urandom_range(3) != 0);
      if (!sx_en) sx_low++;
    end else begin
      sx_en = 1'b1;
    end
    sysex_valid = sx_en && (sx_q.size() > 0);
    sysex_data  = (sx_q.size() > 0) ? sx_q[0][7:0] : 8'h00;
    sysex_last  = (sx_q.size() > 0) ? sx_q[0][8] : 1'b0;
    msg_valid   = (m_q.size() > 0);
    msg_data    = (m_q.size() > 0) ? m_q[0][23:0] : 24'h0;
    msg_len     = (m_q.size() > 0) ? m_q[0][25:24] : 2'd0;
    rt_valid    = (rt_q.size() > 0);
    rt_data     = (rt_q.size() > 0) ? rt_q[0] : 8'h00;
    tx_ready    = rnd_ready ? ($urandom_range(3) != 0) : tx_rdy_fix;
  endtask

  // One clock: sample at the falling edge, apply pops and new inputs just after the rising edge.
  task automatic step();
    logic sp, mp, rp;
    @(negedge clk);
    if (hold_chk) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== held) begin
        bad++;
        $display("FAIL hold: tx_valid=%b tx_data=%h, required 1/%h", tx_valid, tx_data, held);
      end
    end
    hold_chk = (tx_valid === 1'b1) && (tx_ready === 1'b0);
    held     = tx_data;
    if (sysex_rd === 1'b1) begin
      total++;
      if (sysex_valid !== 1'b1) begin
        bad++;
        $display("FAIL sysex_rd_empty: sysex_rd=1 with sysex_valid=%b, required 1", sysex_valid);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (sysex_abort === 1'b1) begin
      abort_cnt++;
      abort_on_eox = (tx_valid === 1'b1) && (tx_data === 8'hF7);
    end
    sp = (sysex_rd === 1'b1);
    mp = (msg_ready === 1'b1);
    rp = (rt_ready === 1'b1);
    sx_pop_flag = sp;
    m_pop_flag  = mp;
    if (sp) begin
      sx_pops++;
      last_sx_pop = sysex_data;
      sx_low = 0;
    end
    if (mp) m_pops++;
    if (rp) rt_pops++;
    @(posedge clk);
    #1;
    cyc++;
    if (sp && sx_q.size() > 0) void'(sx_q.pop_front());
    if (mp && m_q.size() > 0) void'(m_q.pop_front());
    if (rp && rt_q.size() > 0) void'(rt_q.pop_front());
    drive();
  endtask

  task automatic run_until_idle(input int max, input string name);
    int n = 0;
    while (!(sx_q.size() == 0 && m_q.size() == 0 && rt_q.size() == 0 &&
             busy === 1'b0 && tx_valid === 1'b0) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, max);
    end
    repeat (2) step();
  endtask

  task automatic push_sysex(input logic [7:0] b, input bit last);
    sx_q.push_back({last, b});
  endtask

  task automatic clear_log();
    tx_log.delete();
    tx_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sx_q.delete(); m_q.delete(); rt_q.delete();
    tx_rdy_fix = 1;
    drive();
    repeat (2) step();
    rst = 1'b0;
    drive();
    step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: %b, required 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: %h, required 00", tx_data); end
    total++; if (sysex_abort !== 1'b0) begin bad++; $display("FAIL reset_abort: %b, required 0", sysex_abort); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: %b, required 0", busy); end
    total++;
    if ({sysex_rd, msg_ready, rt_ready} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pops: %b, required 000", {sysex_rd, msg_ready, rt_ready});
    end
    clear_log();
  endtask

  task automatic test_short_msg();
    logic [7:0] exp[$];
    int m0;
    exp = '{8'h90, 8'h3C, 8'h64};
    clear_log();
    m0 = m_pops;
    m_q.push_back({2'd3, 24'h903C64});
    drive();
    run_until_idle(50, "short_msg");
    total++;
    if (tx_log.size() != exp.size()) begin
      bad++;
      $display("FAIL short_len: %0d bytes, required %0d", tx_log.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        total++;
        if (tx_log[i] !== exp[i]) begin
          bad++;
          $display("FAIL short_byte%0d: %h, required %h", i, tx_log[i], exp[i]);
        end
      end
      total++;
      if (tx_cyc[2] - tx_cyc[0] != 2) begin
        bad++;
        $display("FAIL short_contig: span %0d cycles, required 2", tx_cyc[2] - tx_cyc[0]);
      end
    end
    total++;
    if (m_pops - m0 != 1) begin
      bad++;
      $display("FAIL short_ready: %0d pulses, required 1", m_pops - m0);
    end
  endtask

  task automatic test_sysex_lock();
    logic [7:0] exp[$];
    exp = '{8'hF0, 8'h7E, 8'h7F, 8'h06, 8'h01, 8'hF7, 8'hB0, 8'h07, 8'h40};
    clear_log();
    for (int i = 0; i < 6; i++) push_sysex(exp[i], i == 5);
    m_q.push_back({2'd3, 24'hB00740});
    drive();
    run_until_idle(80, "sysex_lock");
    total++;
    if (tx_log.size() != exp.size()) begin
      bad++;
      $display("FAIL lock_len: %0d bytes, required %0d", tx_log.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        total++;
        if (tx_log[i] !== exp[i]) begin
          bad++;
          $display("FAIL lock_byte%0d: %h, required %h", i, tx_log[i], exp[i]);
        end
      end
      total++;
      if (tx_cyc[5] - tx_cyc[0] != 5) begin
        bad++;
        $display("FAIL lock_contig: span %0d cycles, required 5", tx_cyc[5] - tx_cyc[0]);
      end
    end
  endtask

  task automatic test_rt_interleave();
    logic [7:0] src[$];
    logic [7:0] exp[$];
    bit raised = 0;
    int r0;
    src = '{8'hF0, 8'h7E, 8'h7F, 8'h06, 8'h01, 8'hF7};
    exp = '{8'hF0, 8'h7E, 8'hF8, 8'h7F, 8'h06, 8'h01, 8'hF7};
    clear_log();
    r0 = rt_pops;
    foreach (src[i]) push_sysex(src[i], i == 5);
    drive();
    for (int n = 0; n < 40; n++) begin
      step();
      if (!raised && sx_pop_flag && last_sx_pop == 8'h7E) begin
        rt_q.push_back(8'hF8);
        drive();
        raised = 1;
      end
    end
    total++;
    if (!raised) begin bad++; $display("FAIL rt_trigger: 7E pop seen=0, required 1"); end
    total++;
    if (tx_log.size() != exp.size()) begin
      bad++;
      $display("FAIL rt_len: %0d bytes, required %0d", tx_log.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        total++;
        if (tx_log[i] !== exp[i]) begin
          bad++;
          $display("FAIL rt_byte%0d: %h, required %h", i, tx_log[i], exp[i]);
        end
      end
    end
    total++;
    if (rt_pops - r0 != 1) begin
      bad++;
      $display("FAIL rt_ready: %0d pulses, required 1", rt_pops - r0);
    end
  endtask

  task automatic test_timeout();
    int a0, s0;
    clear_log();
    a0 = abort_cnt;
    abort_on_eox = 0;
    push_sysex(8'hF0, 0);
    push_sysex(8'h43, 0);
    drive();
    run_until_idle(60, "timeout");
    total++;
    if (tx_log.size() != 3) begin
      bad++;
      $display("FAIL to_len: %0d bytes, required 3", tx_log.size());
    end else begin
      total++;
      if (tx_log[2] !== 8'hF7 || tx_log[1] !== 8'h43) begin
        bad++;
        $display("FAIL to_bytes: %h %h, required 43 F7", tx_log[1], tx_log[2]);
      end
      total++;
      if (tx_cyc[2] - tx_cyc[1] != TO + 1) begin
        bad++;
        $display("FAIL to_delay: %0d cycles, required %0d", tx_cyc[2] - tx_cyc[1], TO + 1);
      end
    end
    total++;
    if (abort_cnt - a0 != 1) begin
      bad++;
      $display("FAIL to_abort_count: %0d, required 1", abort_cnt - a0);
    end
    total++;
    if (!abort_on_eox) begin bad++; $display("FAIL to_abort_align: 0, required 1"); end
    // Tail of the aborted message must be drained silently.
    s0 = sx_pops;
    push_sysex(8'h10, 0);
    push_sysex(8'hF7, 1);
    drive();
    run_until_idle(20, "drop");
    total++;
    if (sx_pops - s0 != 2) begin
      bad++;
      $display("FAIL drop_pops: %0d, required 2", sx_pops - s0);
    end
    total++;
    if (tx_log.size() != 3) begin
      bad++;
      $display("FAIL drop_silent: %0d bytes, required 3", tx_log.size());
    end
    push_sysex(8'hF0, 0);
    push_sysex(8'h01, 0);
    push_sysex(8'hF7, 1);
    drive();
    run_until_idle(30, "drop_clear");
    total++;
    if (tx_log.size() != 6 || tx_log[tx_log.size()-2] !== 8'h01) begin
      bad++;
      $display("FAIL drop_clear: %0d bytes, required 6 ending 01 F7", tx_log.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    int s0, m0, r0, a0, n;
    exp = '{8'hF0, 8'hFA, 8'h01, 8'h02, 8'hF7, 8'hE0, 8'h12, 8'h34};
    clear_log();
    tx_rdy_fix = 1;
    push_sysex(8'hF0, 0); push_sysex(8'h01, 0); push_sysex(8'h02, 0); push_sysex(8'hF7, 1);
    drive();
    n = 0;
    do begin step(); n++; end while (!(sx_pop_flag && last_sx_pop == 8'hF0) && n < 10);
    total++;
    if (n >= 10) begin bad++; $display("FAIL bp_start: F0 not popped in 10 cycles"); end
    tx_rdy_fix = 0;
    m_q.push_back({2'd3, 24'hE01234});
    rt_q.push_back(8'hFA);
    drive();
    s0 = sx_pops; m0 = m_pops; r0 = rt_pops; a0 = abort_cnt;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hF0) begin
        bad++;
        $display("FAIL bp_stable%0d: %b/%h, required 1/F0", i, tx_valid, tx_data);
      end
    end
    total++;
    if (sx_pops != s0 || m_pops != m0 || rt_pops != r0) begin
      bad++;
      $display("FAIL bp_pops: %0d, required 0", (sx_pops - s0) + (m_pops - m0) + (rt_pops - r0));
    end
    total++;
    if (abort_cnt != a0) begin bad++; $display("FAIL bp_no_abort: %0d, required 0", abort_cnt - a0); end
    tx_rdy_fix = 1;
    drive();
    run_until_idle(60, "backpressure");
    total++;
    if (tx_log.size() != exp.size()) begin
      bad++;
      $display("FAIL bp_len: %0d bytes, required %0d", tx_log.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        total++;
        if (tx_log[i] !== exp[i]) begin
          bad++;
          $display("FAIL bp_byte%0d: %h, required %h", i, tx_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_edge_reset();
    logic [7:0] exp[$];
    int m0, n;
    exp = '{8'h90, 8'hF0, 8'hF7, 8'hC0, 8'h05};
    clear_log();
    m0 = m_pops;
    m_q.push_back({2'd0, 24'h800000});
    drive();
    run_until_idle(10, "len0");
    total++;
    if (m_pops - m0 != 1) begin bad++; $display("FAIL len0_ready: %0d, required 1", m_pops - m0); end
    total++;
    if (tx_log.size() != 0) begin bad++; $display("FAIL len0_tx: %0d bytes, required 0", tx_log.size()); end
    m_q.push_back({2'd3, 24'h903040});
    drive();
    n = 0;
    do begin step(); n++; end while (!m_pop_flag && n < 10);
    rst = 1'b1;
    drive();
    step();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: tx_valid=%b busy=%b, required 0/0", tx_valid, busy);
    end
    rst = 1'b0;
    push_sysex(8'hF0, 0);
    push_sysex(8'hF7, 1);
    m_q.push_back({2'd2, 24'hC00500});
    drive();
    run_until_idle(40, "rst_tie");
    total++;
    if (tx_log.size() != exp.size()) begin
      bad++;
      $display("FAIL tie_len: %0d bytes, required %0d", tx_log.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        total++;
        if (tx_log[i] !== exp[i]) begin
          bad++;
          $display("FAIL tie_byte%0d: %h, required %h", i, tx_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] sx_bytes[$], m_bytes[$], rt_exp[$], rest[$], rts[$];
    int sx_lens[$], m_lens[$];
    int rt_left, p, sb, si, mb, mi, len;
    logic [7:0] b, st, d1, d2;
    logic [1:0] ml;
    bit ok;
    clear_log();
    for (int s = 0; s < 5; s++) begin
      len = $urandom_range(2, 6);
      for (int k = 0; k < len; k++) begin
        b = (k == 0) ? 8'hF0 : (k == len - 1) ? 8'hF7 : 8'($urandom_range(0, 127));
        push_sysex(b, k == len - 1);
        sx_bytes.push_back(b);
      end
      sx_lens.push_back(len);
    end
    for (int m = 0; m < 8; m++) begin
      ml = 2'($urandom_range(0, 3));
      st = 8'(8'h80 + $urandom_range(0, 111));
      d1 = 8'($urandom_range(0, 127));
      d2 = 8'($urandom_range(0, 127));
      m_q.push_back({ml, st, d1, d2});
      if (ml > 0) m_bytes.push_back(st);
      if (ml > 1) m_bytes.push_back(d1);
      if (ml > 2) m_bytes.push_back(d2);
      if (ml > 0) m_lens.push_back(int'(ml));
    end
    rt_left = 10;
    rnd_ready = 1;
    rnd_sx = 1;
    drive();
    for (int n = 0; n < 4000; n++) begin
      if (rt_left > 0 && rt_q.size() == 0 && $urandom_range(5) == 0) begin
        b = 8'(8'hF8 + $urandom_range(0, 7));
        rt_q.push_back(b);
        rt_exp.push_back(b);
        rt_left--;
        drive();
      end
      step();
      if (rt_left == 0 && sx_q.size() == 0 && m_q.size() == 0 && rt_q.size() == 0) break;
    end
    rnd_ready = 0;
    rnd_sx = 0;
    tx_rdy_fix = 1;
    drive();
    run_until_idle(200, "random");
    total++;
    if (rt_left != 0) begin bad++; $display("FAIL rnd_rt_left: %0d, required 0", rt_left); end
    foreach (tx_log[i]) begin
      if (tx_log[i] >= 8'hF8) rts.push_back(tx_log[i]);
      else rest.push_back(tx_log[i]);
    end
    total++;
    if (rts.size() != rt_exp.size()) begin
      bad++;
      $display("FAIL rnd_rt_count: %0d, required %0d", rts.size(), rt_exp.size());
    end else begin
      foreach (rt_exp[i]) begin
        total++;
        if (rts[i] !== rt_exp[i]) begin
          bad++;
          $display("FAIL rnd_rt%0d: %h, required %h", i, rts[i], rt_exp[i]);
        end
      end
    end
    // Non-realtime output must be whole messages, each source in order.
    p = 0; sb = 0; si = 0; mb = 0; mi = 0;
    while (p < rest.size()) begin
      total++;
      ok = 1;
      if (si < sx_lens.size() && rest[p] == 8'hF0) begin
        len = sx_lens[si];
        for (int k = 0; k < len; k++)
          if (p + k >= rest.size() || rest[p+k] !== sx_bytes[sb+k]) ok = 0;
        if (!ok) begin
          bad++;
          $display("FAIL rnd_sysex%0d: byte %h at %0d, required message start %h", si, rest[p], p,
                   sx_bytes[sb]);
          break;
        end
        p += len; sb += len; si++;
      end else if (mi < m_lens.size()) begin
        len = m_lens[mi];
        for (int k = 0; k < len; k++)
          if (p + k >= rest.size() || rest[p+k] !== m_bytes[mb+k]) ok = 0;
        if (!ok) begin
          bad++;
          $display("FAIL rnd_msg%0d: byte %h at %0d, required message start %h", mi, rest[p], p,
                   m_bytes[mb]);
          break;
        end
        p += len; mb += len; mi++;
      end else begin
        bad++;
        $display("FAIL rnd_extra: byte %h at %0d, required none", rest[p], p);
        break;
      end
    end
    total++;
    if (si != sx_lens.size() || mi != m_lens.size()) begin
      bad++;
      $display("FAIL rnd_complete: sysex %0d/%0d msg %0d/%0d, required all", si, sx_lens.size(),
               mi, m_lens.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive();
    test_reset();
    test_short_msg();
    test_sysex_lock();
    test_rt_interleave();
    test_timeout();
    test_backpressure();
    test_edge_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
